// File: rtl/cond_jump_ctrl_pkg.sv
// Shared types and constants for the conditional-jump sequencer.
package cond_jump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_EVAL,
        ST_FAULT
    } state_e;

    typedef enum logic [2:0] {
        CC_NEVER  = 3'd0,
        CC_EQ     = 3'd1,
        CC_LT     = 3'd2,
        CC_LE     = 3'd3,
        CC_ALWAYS = 3'd4,
        CC_NE     = 3'd5,
        CC_GE     = 3'd6,
        CC_GT     = 3'd7
    } cond_e;

    localparam logic [1:0]  COND_PREFIX   = 2'b11;
    localparam int unsigned FETCH_TIMEOUT = 16;
    localparam int unsigned WAIT_W        = $clog2(FETCH_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

    function automatic logic is_cond_instr(input logic [7:0] b);
        return b[7:6] == COND_PREFIX;
    endfunction

endpackage

// File: rtl/cond_jump_ctrl_if.sv
// Fetch and issue handshakes between the sequencer, instruction memory and datapath.
interface cond_jump_ctrl_if;

    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_data,
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_data,
        input  instr_valid,
        input  instr,
        output instr_ready
    );

endinterface

// File: rtl/cond_jump_ctrl_conditions.sv
// Conditions evaluator: tests a signed byte against a 3-bit condition code.
module cond_jump_ctrl_conditions
    import cond_jump_ctrl_pkg::*;
(
    input  logic [7:0] value_i,
    input  logic [2:0] cond_i,
    output logic       true_o
);

    logic zero;
    logic neg;

    assign zero = (value_i == '0);
    assign neg  = value_i[7];

    always_comb begin
        true_o = 1'b0;
        case (cond_e'(cond_i))
            CC_NEVER:  true_o = 1'b0;
            CC_EQ:     true_o = zero;
            CC_LT:     true_o = neg;
            CC_LE:     true_o = neg | zero;
            CC_ALWAYS: true_o = 1'b1;
            CC_NE:     true_o = ~zero;
            CC_GE:     true_o = ~neg;
            CC_GT:     true_o = ~neg & ~zero;
            default:   true_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_jump_ctrl.sv
// Fetch / issue / conditional-jump sequencer with a sticky fetch-timeout fault.
module cond_jump_ctrl
    import cond_jump_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       r3,
    input  logic [7:0]       r0,
    output logic [7:0]       pc,
    output logic             taken,
    output logic             fault,
    cond_jump_ctrl_if.master bus
);

    state_e            state_q;
    logic [7:0]        pc_q;
    logic [7:0]        instr_q;
    logic              req_q;
    logic              valid_q;
    logic              taken_q;
    logic              fault_q;
    logic [WAIT_W-1:0] wait_q;

    logic              cond_true;
    logic [7:0]        pc_inc;

    assign pc_inc = pc_q + 8'd1;

    cond_jump_ctrl_conditions u_cond (
        .value_i (r3),
        .cond_i  (instr_q[2:0]),
        .true_o  (cond_true)
    );

    // taken is registered, so it is seen in the cycle the jump target appears on pc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            fault_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            taken_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                        wait_q  <= '0;
                    end
                end
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_data;
                        req_q   <= 1'b0;
                        if (is_cond_instr(bus.imem_data)) begin
                            state_q <= ST_EVAL;
                        end else begin
                            state_q <= ST_ISSUE;
                            valid_q <= 1'b1;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= ST_FAULT;
                        req_q   <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_ISSUE: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_inc;
                        state_q <= en ? ST_FETCH : ST_IDLE;
                        req_q   <= en;
                        wait_q  <= '0;
                    end
                end
                ST_EVAL: begin
                    pc_q    <= cond_true ? r0 : pc_inc;
                    taken_q <= cond_true;
                    state_q <= en ? ST_FETCH : ST_IDLE;
                    req_q   <= en;
                    wait_q  <= '0;
                end
                ST_FAULT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc              = pc_q;
    assign taken           = taken_q;
    assign fault           = fault_q;
    assign bus.imem_req    = req_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;

endmodule

// File: doc/cond_jump_ctrl.md
COND_JUMP_CTRL -- requirements
Module: cond_jump_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 en  input  1  run enable, sampled in IDLE.
REQ-005 pc  output  8  current program counter.
REQ-006 imem_req  output  1  fetch request, held until imem_ack.
REQ-007 imem_ack  input  1  fetch complete; imem_data valid this cycle.
REQ-008 imem_data  input  8  fetched instruction byte.
REQ-009 instr_valid  output  1  non-condition instruction offered to datapath.
REQ-010 instr  output  8  offered instruction byte, stable while instr_valid=1.
REQ-011 instr_ready  input  1  datapath accepts instr.
REQ-012 r3  input  8  signed condition operand.
REQ-013 r0  input  8  jump target.
REQ-014 taken  output  1  one-cycle pulse when a jump is taken.
REQ-015 fault  output  1  sticky fetch-timeout flag.

Function
REQ-016 SHALL implement the states IDLE, FETCH, ISSUE, EVAL and FAULT.
REQ-017 IDLE: the block SHALL move to FETCH when en=1, and SHALL otherwise stay in IDLE.
REQ-018 FETCH: imem_req SHALL be 1.
REQ-019 FETCH: on imem_ack, instr SHALL latch imem_data.
REQ-020 FETCH: an acked byte with imem_data[7:6]=2'b11 SHALL send the block to EVAL; any other byte SHALL send it to ISSUE.
REQ-021 imem_ack SHALL be honoured in the first FETCH cycle, giving zero wait states.
REQ-022 FETCH timeout: the wait counter SHALL count cycles with no ack and reset to 0 on entering FETCH.
REQ-023 After 16 cycles in FETCH without imem_ack, the block SHALL enter FAULT with fault=1.
REQ-024 ISSUE: instr_valid SHALL be 1.
REQ-025 ISSUE: on the cycle where instr_ready=1, pc SHALL become pc+1 modulo 256.
REQ-026 On leaving ISSUE, the next state SHALL be FETCH if en=1, else IDLE.
REQ-027 EVAL (one cycle): condition code cond=instr[2:0] SHALL be evaluated against r3 as signed.
REQ-028 Condition codes SHALL be: 0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
REQ-029 EVAL: if the condition is true, pc SHALL become r0 and taken SHALL pulse for that cycle.
REQ-030 EVAL: if the condition is false, pc SHALL become pc+1 modulo 256.
REQ-031 On leaving EVAL, the next state SHALL be FETCH if en=1, else IDLE.
REQ-032 r3 and r0 SHALL be sampled in the EVAL cycle only.
REQ-033 pc SHALL wrap from 255 to 0 on increment.
REQ-034 A jump to 255 SHALL be legal.
REQ-035 Deasserting en mid-instruction SHALL complete the current instruction, including its PC update, before IDLE.
REQ-036 FAULT SHALL be terminal until rst: all handshake outputs 0, pc frozen, fault=1.
REQ-037 Each instruction SHALL update pc exactly once.
REQ-038 instr_valid and imem_req SHALL never both be 1.

Reset
REQ-039 While rst=1: state=IDLE, pc=0, instr=0, imem_req=0, instr_valid=0, taken=0, fault=0, wait counter=0.
REQ-040 rst asserted mid-FETCH or mid-ISSUE SHALL abandon the transaction immediately, with no pc update.

Structure
REQ-041 A shared package SHALL hold the state enum, COND_PREFIX=2'b11, FETCH_TIMEOUT=16 and the condition-code constants.
REQ-042 Condition evaluation SHALL be one instance of the team's existing Conditions evaluator (byte in, 3-bit cond, 1-bit out), fed r3 and instr[2:0].

Verification
REQ-043 Scenario: reset, en=1, imem_data=8'h05, ack on first request, instr_ready=1 next cycle -> instr_valid one cycle, pc 0->1, no taken.
REQ-044 Scenario: imem_data=8'hC1 (cond ==0), r3=0, r0=8'h40 -> EVAL one cycle after ack, taken pulse, pc=8'h40.
REQ-045 Scenario: cond codes 2/6/7 with r3=8'hFF (-1) -> taken only for code 2; pc=pc+1 for 6 and 7.
REQ-046 Scenario: pc=255, non-condition instruction accepted -> pc=0.
REQ-047 Scenario: imem_ack withheld 16 cycles -> fault=1, imem_req=0, pc unchanged; stays until rst.
REQ-048 Scenario: en dropped during ISSUE with instr_ready delayed 3 cycles, plus async rst pulse in FETCH -> instruction completes, pc+1, IDLE; rst forces pc=0 within the same cycle.
